// File: rtl/pmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arb_pkg
//  Description : Shared types and default widths for the physical-memory
//                port arbiter (FSM state encoding, port selector).
//  Revision    : 1.0 - initial release
// ============================================================================
package pmem_arb_pkg;

    localparam int c_LINE_W = 256;
    localparam int c_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_sel_t;

endpackage
`default_nettype wire

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pmem_arbiter
//  Description : Round-robin arbiter placing the i-cache and d-cache line
//                requests onto one single-port physical memory. One request
//                is in flight at a time; every output is registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module pmem_arbiter
    import pmem_arb_pkg::*;
#(
    parameter int LINE_W = pmem_arb_pkg::c_LINE_W,
    parameter int ADDR_W = pmem_arb_pkg::c_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    // i-cache side
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    // d-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    // physical memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    port_sel_t         r_last_grant;
    port_sel_t         r_owner;
    logic              r_is_write;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic [LINE_W-1:0] r_line;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_i_resp;
    logic              r_d_resp;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;

    logic              w_i_req;
    logic              w_d_req;
    logic              w_grant_valid;
    port_sel_t         w_grant;
    logic              w_grant_wr;
    logic [ADDR_W-1:0] w_grant_addr;
    logic [LINE_W-1:0] w_grant_wdata;
    logic [LINE_W-1:0] w_resp_line;

    // Pick the requester: a lone requester wins, a tie goes to whoever was not served last.
    always_comb begin
        w_i_req       = i_read | i_write;
        w_d_req       = d_read | d_write;
        w_grant_valid = w_i_req | w_d_req;
        w_grant       = PORT_I;
        if (w_i_req && w_d_req) begin
            w_grant = (r_last_grant == PORT_I) ? PORT_D : PORT_I;
        end else if (w_d_req) begin
            w_grant = PORT_D;
        end
        // A port raising read and write together is handled as a write.
        w_grant_wr    = (w_grant == PORT_I) ? i_write   : d_write;
        w_grant_addr  = (w_grant == PORT_I) ? i_address : d_address;
        w_grant_wdata = (w_grant == PORT_I) ? i_wdata   : d_wdata;
        // Writes hand back whatever line is already latched; reads take the fresh memory line.
        w_resp_line   = r_is_write ? r_line : mem_rdata;
    end

    // Arbitration FSM with latched request and registered downstream/upstream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_D;
            r_owner      <= PORT_I;
            r_is_write   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_line       <= '0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner     <= w_grant;
                        r_is_write  <= w_grant_wr;
                        r_addr      <= w_grant_addr;
                        r_wdata     <= w_grant_wdata;
                        r_mem_read  <= ~w_grant_wr;
                        r_mem_write <= w_grant_wr;
                        r_state     <= BUSY;
                    end
                end
                BUSY: begin
                    // Upstream strobes are not looked at here; only memory completion moves on.
                    if (mem_resp) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_line      <= w_resp_line;
                        if (r_owner == PORT_I) begin
                            r_i_resp  <= 1'b1;
                            r_i_rdata <= w_resp_line;
                        end else begin
                            r_d_resp  <= 1'b1;
                            r_d_rdata <= w_resp_line;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_last_grant <= r_owner;
                    r_state      <= TURN;
                end
                TURN: begin
                    // Dead cycle lets the finished owner drop its strobe before re-arbitration.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;
    assign i_resp      = r_i_resp;
    assign d_resp      = r_d_resp;
    assign i_rdata     = r_i_rdata;
    assign d_rdata     = r_d_rdata;

    // Simultaneous read and write on one port is a caller protocol error.
    a_i_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(i_read && i_write));
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule
`default_nettype wire
